// File: rtl/trg_frame_builder.sv
// ============================================================================
// trg_frame_builder : wraps each TRIGGERED window into a header/data/footer
// frame, buffered in a FWFT FIFO and drained on an AXI4-Stream master.
// Revision: 1.0
// ============================================================================
`default_nettype none

module trg_frame_builder #(
  parameter int          TIME_STAMP_WIDTH     = 44,
  parameter int          ADC_RESOLUTION_WIDTH = 12,
  parameter int          TDATA_WIDTH          = 128,
  parameter int          FIFO_DEPTH           = 16,
  parameter int          COUNT_WIDTH          = 16,
  parameter logic [7:0]  HEADER_MAGIC         = 8'hAA,
  parameter logic [7:0]  FOOTER_MAGIC         = 8'h55
) (
  input  logic                             AXIS_ACLK,
  input  logic                             AXIS_ARESET,
  input  logic                             TRIGGERED,
  input  logic [TDATA_WIDTH-1:0]           DATA,
  input  logic                             VALID,
  input  logic [TIME_STAMP_WIDTH-1:0]      TIME_STAMP,
  input  logic [ADC_RESOLUTION_WIDTH-1:0]  BASELINE_WHEN_HIT,
  output logic [TDATA_WIDTH-1:0]           M_AXIS_TDATA,
  output logic                             M_AXIS_TVALID,
  input  logic                             M_AXIS_TREADY,
  output logic                             M_AXIS_TLAST,
  output logic [COUNT_WIDTH-1:0]           DROP_CNT,
  output logic [$clog2(FIFO_DEPTH):0]      FIFO_LEVEL
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0]          DEPTH_L = LW'(FIFO_DEPTH);
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FRAME = 2'd1,
    S_DROP  = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic                    trig_q, trig_d;
  logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]           level_q, level_d;
  logic [COUNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                    trunc_q, trunc_d;
  logic [COUNT_WIDTH-1:0]  drop_q, drop_d;

  // Entry = {is_footer, word}
  logic [TDATA_WIDTH:0]    mem_q [FIFO_DEPTH];

  logic [LW-1:0]           free;
  logic                    rise, empty, pop;
  logic                    we0, we1;
  logic [TDATA_WIDTH:0]    w0, w1;
  logic [TDATA_WIDTH-1:0]  hdr, ftr;
  logic [1:0]              n_wr;
  logic [TDATA_WIDTH:0]    head;

  assign free  = DEPTH_L - level_q;
  assign rise  = TRIGGERED & ~trig_q;
  assign empty = (level_q == '0);
  assign pop   = ~empty & M_AXIS_TREADY;
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    hdr = '0;
    hdr[TDATA_WIDTH-1 -: 8]              = HEADER_MAGIC;
    hdr[TIME_STAMP_WIDTH-1:0]            = TIME_STAMP;
    hdr[64 +: ADC_RESOLUTION_WIDTH]      = BASELINE_WHEN_HIT;
    ftr = '0;
    ftr[TDATA_WIDTH-1 -: 8]              = FOOTER_MAGIC;
    ftr[COUNT_WIDTH-1:0]                 = cnt_q;
    ftr[32]                              = trunc_q;
  end

  always_comb begin
    state_d = state_q;
    trig_d  = TRIGGERED;
    cnt_d   = cnt_q;
    trunc_d = trunc_q;
    drop_d  = drop_q;
    we0     = 1'b0;
    we1     = 1'b0;
    w0      = '0;
    w1      = '0;
    case (state_q)
      S_IDLE: begin
        if (rise) begin
          // Three slots: header, optional first word, and the reserved footer
          if (free >= LW'(3)) begin
            we0     = 1'b1;
            w0      = {1'b0, hdr};
            we1     = VALID;
            w1      = {1'b0, DATA};
            cnt_d   = {{(COUNT_WIDTH-1){1'b0}}, VALID};
            trunc_d = 1'b0;
            state_d = S_FRAME;
          end else begin
            if (drop_q != CNT_MAX) drop_d = drop_q + 1'b1;
            state_d = S_DROP;
          end
        end
      end
      S_FRAME: begin
        if (TRIGGERED) begin
          if (VALID) begin
            if (free >= LW'(2)) begin
              we0 = 1'b1;
              w0  = {1'b0, DATA};
              if (cnt_q == CNT_MAX) trunc_d = 1'b1;
              else                  cnt_d   = cnt_q + 1'b1;
            end else begin
              trunc_d = 1'b1;
            end
          end
        end else begin
          we0     = 1'b1;
          w0      = {1'b1, ftr};
          state_d = S_IDLE;
        end
      end
      S_DROP: begin
        if (!TRIGGERED) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    n_wr     = {1'b0, we0} + {1'b0, we1};
    wr_ptr_d = wr_ptr_q + AW'(n_wr);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    level_d  = level_q + LW'(n_wr) - LW'(pop);
  end

  always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
    if (AXIS_ARESET) begin
      state_q  <= S_IDLE;
      trig_q   <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      cnt_q    <= '0;
      trunc_q  <= 1'b0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      trig_q   <= trig_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      cnt_q    <= cnt_d;
      trunc_q  <= trunc_d;
      drop_q   <= drop_d;
    end
  end

  // Storage needs no reset: validity is tracked by the pointers and level
  always_ff @(posedge AXIS_ACLK) begin
    if (we0) mem_q[wr_ptr_q] <= w0;
    if (we1) mem_q[wr_ptr_q + AW'(1)] <= w1;
  end

  assign M_AXIS_TVALID = ~empty;
  assign M_AXIS_TDATA  = empty ? '0 : head[TDATA_WIDTH-1:0];
  assign M_AXIS_TLAST  = ~empty & head[TDATA_WIDTH];
  assign DROP_CNT      = drop_q;
  assign FIFO_LEVEL    = level_q;

endmodule

`default_nettype wire

// File: tb/tb_trg_frame_builder.sv
// ============================================================================
// tb_trg_frame_builder : directed scenarios plus random traffic checked
// against a frame-level reference model. Revision: 1.0
// ============================================================================
`default_nettype none

module tb_trg_frame_builder;

  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          trig;
  logic [127:0]  data;
  logic          valid;
  logic [43:0]   ts;
  logic [11:0]   bl;
  logic [127:0]  tdata;
  logic          tvalid;
  logic          tready;
  logic          tlast;
  logic [15:0]   drop_cnt;
  logic [4:0]    level;

  int n_tests = 0;
  int n_fail  = 0;

  trg_frame_builder dut (
    .AXIS_ACLK         (clk),
    .AXIS_ARESET       (rst),
    .TRIGGERED         (trig),
    .DATA              (data),
    .VALID             (valid),
    .TIME_STAMP        (ts),
    .BASELINE_WHEN_HIT (bl),
    .M_AXIS_TDATA      (tdata),
    .M_AXIS_TVALID     (tvalid),
    .M_AXIS_TREADY     (tready),
    .M_AXIS_TLAST      (tlast),
    .DROP_CNT          (drop_cnt),
    .FIFO_LEVEL        (level)
  );

  always #5 clk = ~clk;

  // Reference model: FIFO contents as a queue of {last, word}
  logic [128:0] mq[$];
  logic [128:0] obs[$];
  bit           m_prev;
  int           m_mode;      // 0 idle, 1 in frame, 2 dropping
  int           m_cnt;
  bit           m_trunc;
  int           m_drop;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [128:0] mk_hdr(input logic [43:0] t, input logic [11:0] b);
    logic [128:0] e;
    e = '0;
    e[127:120] = 8'hAA;
    e[43:0]    = t;
    e[75:64]   = b;
    return e;
  endfunction

  function automatic logic [128:0] mk_ftr(input int c, input bit tr);
    logic [128:0] e;
    e = '0;
    e[128]     = 1'b1;
    e[127:120] = 8'h55;
    e[15:0]    = 16'(c);
    e[32]      = tr;
    return e;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_prev  = 1'b1;
    m_mode  = 0;
    m_cnt   = 0;
    m_trunc = 1'b0;
    m_drop  = 0;
  endtask

  task automatic check_outputs();
    logic [128:0] h;
    h = (mq.size() != 0) ? mq[0] : '0;
    chk("tvalid", tvalid, mq.size() != 0);
    chk("tdata",  tdata,  h[127:0]);
    chk("tlast",  tlast,  h[128]);
    chk("level",  level,  mq.size());
    chk("drop",   drop_cnt, m_drop);
  endtask

  // One clock: update model with the inputs present at the edge, then compare
  task automatic step();
    int  free;
    bit  rise;
    logic [128:0] w[$];
    if (tvalid && tready) obs.push_back({tlast, tdata});
    free = DEPTH - mq.size();
    rise = trig && !m_prev;
    if (m_mode == 0) begin
      if (rise && free >= 3) begin
        w.push_back(mk_hdr(ts, bl));
        m_cnt = 0; m_trunc = 0;
        if (valid) begin w.push_back({1'b0, data}); m_cnt = 1; end
        m_mode = 1;
      end else if (rise) begin
        if (m_drop < 65535) m_drop++;
        m_mode = 2;
      end
    end else if (m_mode == 1) begin
      if (!trig) begin
        w.push_back(mk_ftr(m_cnt, m_trunc));
        m_mode = 0;
      end else if (valid) begin
        if (free >= 2) begin
          w.push_back({1'b0, data});
          if (m_cnt == 65535) m_trunc = 1; else m_cnt++;
        end else m_trunc = 1;
      end
    end else if (!trig) m_mode = 0;
    if (mq.size() != 0 && tready) void'(mq.pop_front());
    foreach (w[i]) mq.push_back(w[i]);
    m_prev = trig;
    @(posedge clk); #1;
    check_outputs();
  endtask

  task automatic drive(input bit t, input bit v);
    trig  = t;
    valid = v;
    data  = {$urandom, $urandom, $urandom, $urandom};
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    chk("rst_tvalid", tvalid, 1'b0);
    chk("rst_level",  level,  5'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_outputs();
  endtask

  initial begin
    int nl;
    logic [128:0] e;
    rst = 1'b0; trig = 1'b0; data = '0; valid = 1'b0;
    ts = 44'h123; bl = 12'h010; tready = 1'b1;
    #1;
    do_reset();
    chk("rst_tdata", tdata, 128'd0);
    chk("rst_tlast", tlast, 1'b0);

    // 1: basic frame, fixed beats
    idle(2);
    obs.delete();
    for (int i = 1; i <= 4; i++) begin
      trig = 1'b1; valid = 1'b1; data = 128'(i); step();
    end
    idle(8);
    chk("t1_nbeats", obs.size(), 6);
    if (obs.size() == 6) begin
      chk("t1_hdr", obs[0], mk_hdr(44'h123, 12'h010));
      for (int i = 1; i <= 4; i++) chk("t1_data", obs[i], 129'(i));
      chk("t1_ftr", obs[5], mk_ftr(4, 1'b0));
    end

    // 2: back-to-back frames
    obs.delete();
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1);
    drive(1'b0, 1'b1);
    for (int i = 0; i < 2; i++) drive(1'b1, 1'b1);
    idle(10);
    nl = 0;
    foreach (obs[i]) nl += int'(obs[i][128]);
    chk("t2_nbeats", obs.size(), 9);
    chk("t2_nlast",  nl, 2);

    // 3: backpressure, long frame truncated by the footer reservation
    tready = 1'b0;
    for (int i = 0; i < 20; i++) drive(1'b1, 1'b1);
    drive(1'b0, 1'b0);
    chk("t3_level", level, 5'd16);

    // 4: FIFO full -> whole frame dropped, then drain
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b1);
    drive(1'b0, 1'b0);
    chk("t4_drop", drop_cnt, 16'd1);
    tready = 1'b1;
    obs.delete();
    idle(20);
    chk("t4_nbeats", obs.size(), 16);
    if (obs.size() == 16) chk("t4_ftr", obs[15], mk_ftr(14, 1'b1));

    // 5: reset mid-frame, released while TRIGGERED stays high
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1);
    trig = 1'b1;
    do_reset();
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1);
    chk("t5_quiet", tvalid, 1'b0);
    idle(1);
    obs.delete();
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1);
    idle(8);
    chk("t5_nbeats", obs.size(), 5);

    // 6: VALID gaps
    obs.delete();
    drive(1'b1, 1'b1); drive(1'b1, 1'b0); drive(1'b1, 1'b1);
    drive(1'b1, 1'b0); drive(1'b1, 1'b1);
    idle(8);
    chk("t6_nbeats", obs.size(), 5);
    if (obs.size() == 5) begin
      e = obs[4];
      chk("t6_cnt", e[15:0], 16'd3);
    end

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) trig = ~trig;
      valid  = ($urandom_range(0, 3) != 0);
      tready = (i % 400 < 150) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 9) < 7);
      ts     = 44'({$urandom, $urandom});
      bl     = 12'($urandom);
      data   = {$urandom, $urandom, $urandom, $urandom};
      step();
    end
    tready = 1'b1;
    idle(25);
    chk("end_empty", tvalid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
